// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - requester, arbiter and RAM signals shared by memory_arbiter
interface memory_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              iwait;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              dwait;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic [1:0]        ramstate;
  logic              ramerr;

  // slave: the arbiter itself; master: the requesters and the RAM model around it
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );
endinterface

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - instruction/data to single RAM port arbiter
// Define ARB_FAIR_EN for round-robin tie breaking; otherwise data always wins ties.
module memory_arbiter (
  input  logic CLK,
  input  logic RST,
  memory_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, IGNT = 2'd1, DGNT = 2'd2} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;

  state_t state_q, state_d;
  logic   d_req, ram_done, ram_err;
  logic   i_cmpl, d_cmpl;
  logic   tie_to_d;

  assign d_req    = bus.dREN | bus.dWEN;
  assign ram_done = (bus.ramstate == RAM_ACCESS) || (bus.ramstate == RAM_ERROR);
  assign ram_err  = (bus.ramstate == RAM_ERROR);
  assign i_cmpl   = (state_q == IGNT) & bus.iREN & ram_done;
  assign d_cmpl   = (state_q == DGNT) & d_req & ram_done;

`ifdef ARB_FAIR_EN
  logic last_d_q;
  assign tie_to_d = ~last_d_q;
`else
  assign tie_to_d = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_req && bus.iREN) state_d = tie_to_d ? DGNT : IGNT;
        else if (d_req)        state_d = DGNT;
        else if (bus.iREN)     state_d = IGNT;
      end
      // A dropped request ends the grant just like a completion does
      IGNT:    if (!bus.iREN || ram_done) state_d = IDLE;
      DGNT:    if (!d_req || ram_done)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
`ifdef ARB_FAIR_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef ARB_FAIR_EN
      if (i_cmpl)      last_d_q <= 1'b0;
      else if (d_cmpl) last_d_q <= 1'b1;
`endif
    end
  end

  always_comb begin
    bus.iwait    = bus.iREN & ~i_cmpl;
    bus.dwait    = d_req & ~d_cmpl;
    bus.iload    = (i_cmpl && !ram_err) ? bus.ramload : '0;
    bus.dload    = (d_cmpl && !ram_err) ? bus.ramload : '0;
    bus.ramerr   = (i_cmpl | d_cmpl) & ram_err;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (state_q)
      IGNT: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
      end
      DGNT: begin
        bus.ramREN   = bus.dREN;
        bus.ramWEN   = bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - scoreboard bench for memory_arbiter (both ARB_FAIR_EN builds)
module tb_memory_arbiter;
  logic CLK = 1'b0;
  logic RST;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] load;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  memory_arbiter dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic push(input logic is_d, input logic [31:0] load);
    exp_t e;
    e.is_d = is_d;
    e.load = load;
    sb.push_back(e);
  endtask

  task automatic cmpl(input logic is_d, input logic [31:0] load);
    exp_t e;
    chk("sb_nonempty", 64'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_port", is_d, e.is_d);
      chk("sb_load", load, e.load);
    end
  endtask

  // a requester with wait low has just completed
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      if (bus.iREN && !bus.iwait) cmpl(1'b0, bus.iload);
      if ((bus.dREN || bus.dWEN) && !bus.dwait) cmpl(1'b1, bus.dload);
    end
  end

  initial begin
    logic        fair;
    logic        is_d;
    logic [31:0] val;
`ifdef ARB_FAIR_EN
    fair = 1'b1;
`else
    fair = 1'b0;
`endif
    RST = 1'b1;
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = 2'b00;
    repeat (2) @(posedge CLK);
    #1;
    smp();
    chk("rst_ren", bus.ramREN, 0);
    chk("rst_wen", bus.ramWEN, 0);
    chk("rst_iwait", bus.iwait, 0);
    chk("rst_dwait", bus.dwait, 0);
    chk("rst_err", bus.ramerr, 0);
    step();
    RST = 1'b0;

    // ties straight after reset
    bus.iREN = 1; bus.iaddr = 32'h80; bus.dREN = 1; bus.daddr = 32'h200;
    bus.ramstate = 2'b10;
    for (int t = 0; t < 4; t++) begin
      is_d = fair ? (t % 2 == 0) : 1'b1;
      val = 32'hA000_0000 | t;
      bus.ramload = val;
      push(is_d, val);
      smp();
      chk("tie_idle_ren", bus.ramREN, 0);
      chk("tie_idle_iwait", bus.iwait, 1);
      chk("tie_idle_dwait", bus.dwait, 1);
      step();
      smp();
      chk("tie_ren", bus.ramREN, 1);
      chk("tie_addr", bus.ramaddr, is_d ? 32'h200 : 32'h80);
      chk("tie_iwait", bus.iwait, is_d);
      step();
    end
    bus.iREN = 0; bus.dREN = 0; bus.ramstate = 2'b00; bus.ramload = 0;
    step();

    // instruction fetch alone with two BUSY cycles
    bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = 2'b01;
    push(1'b0, 32'h2001_0005);
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("if_wait", bus.iwait, 1);
      chk("if_ren", bus.ramREN, (i > 0));
      if (i > 0) chk("if_addr", bus.ramaddr, 32'h40);
      step();
    end
    bus.ramstate = 2'b10; bus.ramload = 32'h2001_0005;
    smp();
    chk("if_done_wait", bus.iwait, 0);
    chk("if_iload", bus.iload, 32'h2001_0005);
    step();
    bus.ramstate = 2'b00; bus.ramload = 0;
    smp();
    chk("if_idle_ren", bus.ramREN, 0);
    chk("if_idle_wait", bus.iwait, 1);
    step();
    bus.iREN = 0;
    smp();
    chk("drop_ren", bus.ramREN, 0);
    chk("drop_wait", bus.iwait, 0);
    step();

    // data write
    bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD_BEEF; bus.ramstate = 2'b01;
    push(1'b1, 32'h0);
    smp();
    chk("wr_idle_wait", bus.dwait, 1);
    chk("wr_idle_wen", bus.ramWEN, 0);
    step();
    smp();
    chk("wr_wen", bus.ramWEN, 1);
    chk("wr_ren", bus.ramREN, 0);
    chk("wr_addr", bus.ramaddr, 32'h100);
    chk("wr_store", bus.ramstore, 32'hDEAD_BEEF);
    chk("wr_busy_wait", bus.dwait, 1);
    step();
    bus.ramstate = 2'b10;
    smp();
    chk("wr_done_wait", bus.dwait, 0);
    step();
    bus.dWEN = 0; bus.dstore = 0; bus.ramstate = 2'b00;
    smp();
    chk("wr_idle_store", bus.ramstore, 0);
    chk("wr_idle_addr", bus.ramaddr, 0);
    step();

    // RAM error on a data read
    bus.dREN = 1; bus.daddr = 32'h300; bus.ramstate = 2'b00;
    push(1'b1, 32'h0);
    smp();
    chk("err_idle", bus.ramerr, 0);
    step();
    bus.ramstate = 2'b11; bus.ramload = 32'hFFFF_FFFF;
    smp();
    chk("err_pulse", bus.ramerr, 1);
    chk("err_dload", bus.dload, 0);
    chk("err_dwait", bus.dwait, 0);
    step();
    smp();
    chk("err_once", bus.ramerr, 0);
    chk("err_next_idle", bus.ramREN, 0);
    chk("err_next_wait", bus.dwait, 1);
    step();
    bus.dREN = 0; bus.ramstate = 2'b00; bus.ramload = 0;
    step();

    // asynchronous reset in the middle of a BUSY data grant
    bus.dREN = 1; bus.daddr = 32'h400; bus.ramstate = 2'b01;
    smp();
    step();
    smp();
    chk("rm_ren_before", bus.ramREN, 1);
    #2;
    RST = 1'b1; bus.iREN = 1; bus.iaddr = 32'h80;
    #1;
    chk("rm_ren", bus.ramREN, 0);
    chk("rm_wen", bus.ramWEN, 0);
    chk("rm_err", bus.ramerr, 0);
    chk("rm_dwait", bus.dwait, 1);
    chk("rm_iwait", bus.iwait, 1);
    step();
    RST = 1'b0; bus.ramstate = 2'b10; bus.ramload = 32'h55AA_55AA;
    push(1'b1, 32'h55AA_55AA);
    smp();
    chk("rm_idle_ren", bus.ramREN, 0);
    step();
    smp();
    chk("rm_grant_addr", bus.ramaddr, 32'h400);
    chk("rm_grant_ren", bus.ramREN, 1);
    step();
    bus.iREN = 0; bus.dREN = 0; bus.ramstate = 2'b00; bus.ramload = 0;
    step();

    chk("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port to one-port memory arbiter for the pipelined MIPS datapath. Shares the single RAM port between the instruction fetch path (read-only) and the data memory path (read/write), so fetch and load/store both reach memory without a second RAM. Sits between the datapath's memory requesters and the RAM model. Grants one requester per transaction and holds the grant until RAM completes the access.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-high reset
- iREN  input  1  instruction read request
- iaddr  input  ADDR_W  instruction address
- iload  output  DATA_W  instruction read data
- iwait  output  1  instruction requester must stall
- dREN  input  1  data read request
- dWEN  input  1  data write request; never asserted together with dREN
- daddr  input  ADDR_W  data address
- dstore  input  DATA_W  data write value
- dload  output  DATA_W  data read data
- dwait  output  1  data requester must stall
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  ADDR_W  RAM address
- ramstore  output  DATA_W  RAM write data
- ramload  input  DATA_W  RAM read data
- ramstate  input  2  RAM status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR
- ramerr  output  1  one-cycle pulse when a granted access ends in ERROR

## Operation
- FSM states: IDLE, IGNT, DGNT. Registered state, reset to IDLE.
- IDLE:
  - data request (dREN|dWEN) -> DGNT.
  - else iREN -> IGNT.
  - else stay.
  - If both are pending, the Configuration section decides.
- IGNT: ramREN=1, ramaddr=iaddr, ramWEN=0.
- DGNT: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
- IDLE: ramREN=ramWEN=0, ramaddr=0, ramstore=0.
- Completion (ramstate==ACCESS while granted):
  - granted requester's wait is 0 that cycle;
  - its load output equals ramload;
  - next state IDLE.
- ERROR while granted:
  - treated as completion; wait=0, load forced to 0, ramerr=1 that cycle;
  - next state IDLE.
- Requester drops its request while granted, before completion: next state IDLE, RAM enables deasserted the same cycle.
- iwait = iREN & ~(state==IGNT & ramstate∈{ACCESS,ERROR}). dwait is defined the same way for (dREN|dWEN) and DGNT.
- iload and dload are 0 when not completing.
- A requester must hold address, data and request stable while its wait is 1.

## Timing
- Arbitration latency: a request present in IDLE at edge k is granted from edge k+1. RAM enables are asserted in the cycle after the edge.
- Minimum transaction: 2 cycles (IDLE sample + 1 ACCESS cycle). Each BUSY cycle adds 1.
- Back-to-back requests pass through IDLE for one cycle between grants. No grant is held across completion.
- All waits, loads and RAM drive signals are combinational from state and inputs. Only the FSM and the last-grant bit are registered.
- Reset (asynchronous, any cycle, including mid-grant):
  - state goes to IDLE and last-grant goes to INSTR immediately;
  - ramREN=ramWEN=0 and ramerr=0 while RST=1;
  - waits equal the raw requests while RST=1.

## Configuration
- ARB_FAIR_EN defined: round-robin on ties.
  - A last-grant register (INSTR/DATA) is updated on every completion or ERROR.
  - In IDLE with both pending, grant the side not in last-grant.
  - After reset the first tie goes to DATA.
- ARB_FAIR_EN undefined: fixed priority, data always wins ties. No last-grant register is built.
- Single-requester behaviour is identical in both builds.

## Test plan
- Instruction fetch alone: iREN=1, iaddr=0x0000_0040, ramstate BUSY 2 cycles then ACCESS with ramload=0x2001_0005. Required: iwait=1 for 3 cycles, then iwait=0 with iload=0x2001_0005; state back to IDLE.
- Data write: dWEN=1, daddr=0x0000_0100, dstore=0xDEAD_BEEF. Required: ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF from the cycle after request; dwait drops on the ACCESS cycle.
- Simultaneous iREN and dREN held for 4 transactions, ramstate ACCESS in every granted cycle:
  - fair build grants D,I,D,I;
  - unfair build grants D,D,D,D while iwait stays 1.
- ERROR: DGNT with ramstate=11. Required: ramerr=1 for exactly one cycle, dload=0, dwait=0, next state IDLE.
- RST asserted mid-DGNT with ramstate BUSY. Required: ramREN/ramWEN=0 in the same cycle. After release with iREN and dREN both pending, the grant goes to data.
